// File: rtl/ecd_pkg.sv
// Shared definitions for the ECD request arbiter: packet widths, response
// field layout, response codes and the arbiter FSM state type.
package ecd_pkg;

  localparam int REQ_W  = 512;
  localparam int RSP_W  = 256;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int RESP_W = 3;

  localparam int RSP_ADDR_LSB = 0;
  localparam int RSP_DATA_LSB = 32;
  localparam int RSP_RESP_LSB = 64;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 3'd0;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 3'd2;
  localparam logic [RESP_W-1:0] RESP_DECERR = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RSP,
    ST_DELIVER
  } arb_state_e;

  function automatic logic [RSP_W-1:0] make_rsp(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] data,
                                                input logic [RESP_W-1:0] resp);
    logic [RSP_W-1:0] r;
    r = '0;
    r[RSP_ADDR_LSB +: ADDR_W] = addr;
    r[RSP_DATA_LSB +: DATA_W] = data;
    r[RSP_RESP_LSB +: RESP_W] = resp;
    return r;
  endfunction

endpackage

// File: rtl/ecd_request_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after
// ptr (wrapping), returned both one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise paths with
    // no request leave them unassigned and a latch is inferred.
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = IDX_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ecd_request_arbiter.sv
// Shares the ECD request/response path among NUM_REQ requesters: round-robin
// grant, one transaction in flight, watchdog-synthesized DECERR on lost responses.
module ecd_request_arbiter
  import ecd_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ*REQ_W-1:0] REQ_TDATA,
  input  logic [NUM_REQ-1:0]       REQ_TVALID,
  output logic [NUM_REQ-1:0]       REQ_TREADY,
  output logic [RSP_W-1:0]         RSP_TDATA,
  output logic [NUM_REQ-1:0]       RSP_TVALID,
  input  logic [NUM_REQ-1:0]       RSP_TREADY,
  output logic [REQ_W-1:0]         AXIS_OUT0_TDATA,
  output logic                     AXIS_OUT0_TVALID,
  output logic                     AXIS_OUT0_TLAST,
  input  logic                     AXIS_OUT0_TREADY,
  output logic [REQ_W-1:0]         AXIS_OUT1_TDATA,
  output logic                     AXIS_OUT1_TVALID,
  output logic                     AXIS_OUT1_TLAST,
  input  logic                     AXIS_OUT1_TREADY,
  input  logic [RSP_W-1:0]         AXIS_IN_TDATA,
  input  logic                     AXIS_IN_TVALID,
  output logic                     AXIS_IN_TREADY,
  output logic                     busy,
  output logic [15:0]              timeout_count,
  output logic [15:0]              stale_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_e       state, state_next;
  logic             active;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [REQ_W-1:0] req_buf;
  logic [RSP_W-1:0] rsp_buf;
  logic             out0_valid, out1_valid;
  logic [WD_W-1:0]  wd_cnt;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               grant_fire, in_fire, send_done, wd_expire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (REQ_TVALID),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // active is low during reset and for the first edge after it, so every
  // combinational ready/valid output reads 0 while resetn is asserted.
  assign grant_fire     = active && (state == ST_IDLE) && grant_valid;
  assign AXIS_IN_TREADY = (active && (state == ST_IDLE)) || (state == ST_WAIT_RSP);
  assign in_fire        = AXIS_IN_TREADY && AXIS_IN_TVALID;
  assign send_done      = (!out0_valid || AXIS_OUT0_TREADY) && (!out1_valid || AXIS_OUT1_TREADY);
  assign wd_expire      = (state == ST_WAIT_RSP) && !AXIS_IN_TVALID && (wd_cnt == WD_LAST);

  assign REQ_TREADY       = grant_fire ? grant : '0;
  assign RSP_TDATA        = rsp_buf;
  assign RSP_TVALID       = (state == ST_DELIVER) ? (NUM_REQ'(1) << owner) : '0;
  assign AXIS_OUT0_TDATA  = req_buf;
  assign AXIS_OUT0_TVALID = out0_valid;
  assign AXIS_OUT0_TLAST  = 1'b1;
  assign AXIS_OUT1_TDATA  = '0;
  assign AXIS_OUT1_TVALID = out1_valid;
  assign AXIS_OUT1_TLAST  = 1'b1;
  assign busy             = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (grant_fire) state_next = ST_SEND;
      ST_SEND:     if (send_done) state_next = ST_WAIT_RSP;
      ST_WAIT_RSP: if (in_fire || wd_expire) state_next = ST_DELIVER;
      ST_DELIVER:  if (RSP_TREADY[owner]) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      active        <= 1'b0;
      rr_ptr        <= '0;
      owner         <= '0;
      req_buf       <= '0;
      rsp_buf       <= '0;
      out0_valid    <= 1'b0;
      out1_valid    <= 1'b0;
      wd_cnt        <= '0;
      timeout_count <= '0;
      stale_count   <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values
      // regardless of statement order.
      state  <= state_next;
      active <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            req_buf    <= REQ_TDATA[grant_idx*REQ_W +: REQ_W];
            owner      <= grant_idx;
            rr_ptr     <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
            out0_valid <= 1'b1;
            out1_valid <= 1'b1;
          end
          if (in_fire && (stale_count != 16'hFFFF)) stale_count <= stale_count + 16'd1;
        end
        ST_SEND: begin
          if (AXIS_OUT0_TREADY) out0_valid <= 1'b0;
          if (AXIS_OUT1_TREADY) out1_valid <= 1'b0;
          wd_cnt <= '0;
        end
        ST_WAIT_RSP: begin
          // A response on the expiry cycle takes priority over the timeout.
          if (AXIS_IN_TVALID) begin
            rsp_buf <= AXIS_IN_TDATA;
          end else if (wd_expire) begin
            rsp_buf <= make_rsp(req_buf[ADDR_W-1:0], '0, RESP_DECERR);
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecd_request_arbiter.sv
// Directed bench for ecd_request_arbiter (NUM_REQ=3, TIMEOUT_CYCLES=16).
module tb_ecd_request_arbiter;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic [N*512-1:0] REQ_TDATA;
  logic [N-1:0]     REQ_TVALID, REQ_TREADY;
  logic [255:0]     RSP_TDATA;
  logic [N-1:0]     RSP_TVALID, RSP_TREADY;
  logic [511:0]     AXIS_OUT0_TDATA, AXIS_OUT1_TDATA;
  logic             AXIS_OUT0_TVALID, AXIS_OUT0_TLAST, AXIS_OUT0_TREADY;
  logic             AXIS_OUT1_TVALID, AXIS_OUT1_TLAST, AXIS_OUT1_TREADY;
  logic [255:0]     AXIS_IN_TDATA;
  logic             AXIS_IN_TVALID, AXIS_IN_TREADY;
  logic             busy;
  logic [15:0]      timeout_count, stale_count;

  int errors = 0;
  int checks = 0;

  logic [511:0] pkt [N];

  ecd_request_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .REQ_TDATA(REQ_TDATA), .REQ_TVALID(REQ_TVALID), .REQ_TREADY(REQ_TREADY),
    .RSP_TDATA(RSP_TDATA), .RSP_TVALID(RSP_TVALID), .RSP_TREADY(RSP_TREADY),
    .AXIS_OUT0_TDATA(AXIS_OUT0_TDATA), .AXIS_OUT0_TVALID(AXIS_OUT0_TVALID),
    .AXIS_OUT0_TLAST(AXIS_OUT0_TLAST), .AXIS_OUT0_TREADY(AXIS_OUT0_TREADY),
    .AXIS_OUT1_TDATA(AXIS_OUT1_TDATA), .AXIS_OUT1_TVALID(AXIS_OUT1_TVALID),
    .AXIS_OUT1_TLAST(AXIS_OUT1_TLAST), .AXIS_OUT1_TREADY(AXIS_OUT1_TREADY),
    .AXIS_IN_TDATA(AXIS_IN_TDATA), .AXIS_IN_TVALID(AXIS_IN_TVALID),
    .AXIS_IN_TREADY(AXIS_IN_TREADY),
    .busy(busy), .timeout_count(timeout_count), .stale_count(stale_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rsp_pkt(input logic [31:0] addr, input logic [31:0] data,
                                           input logic [2:0] resp);
    logic [255:0] r;
    r = '0;
    r[31:0]  = addr;
    r[63:32] = data;
    r[66:64] = resp;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    resetn = 1'b0;
    REQ_TVALID = '0; RSP_TREADY = '0; AXIS_OUT0_TREADY = 1'b0; AXIS_OUT1_TREADY = 1'b0;
    AXIS_IN_TVALID = 1'b0; AXIS_IN_TDATA = '0;
    tick; tick;
    resetn = 1'b1;
    tick;
  endtask

  // Full transaction for the expected owner: grant, both request channels, ECD
  // response, delivery. REQ_TVALID of the owner is dropped after grant if drop=1.
  task automatic run_txn(input int owner, input logic [255:0] rsp, input bit drop, input string tag);
    logic [N-1:0] exp_oh;
    int n;
    exp_oh = N'(1) << owner;
    #1;
    n = 0;
    while (REQ_TREADY == '0 && n < 20) begin tick; n++; end
    if (REQ_TREADY !== exp_oh) begin errors++; $display("FAIL %s_grant: got %b expected %b", tag, REQ_TREADY, exp_oh); end
    checks++;
    tick;
    if (drop) REQ_TVALID[owner] = 1'b0;
    #1;
    if (AXIS_OUT0_TVALID !== 1'b1 || AXIS_OUT1_TVALID !== 1'b1) begin errors++; $display("FAIL %s_out_valid: got %b%b expected 11", tag, AXIS_OUT0_TVALID, AXIS_OUT1_TVALID); end
    checks++;
    if (AXIS_OUT0_TDATA !== pkt[owner]) begin errors++; $display("FAIL %s_out0_data: got %h expected %h", tag, AXIS_OUT0_TDATA[63:0], pkt[owner][63:0]); end
    checks++;
    if (AXIS_OUT1_TDATA !== '0) begin errors++; $display("FAIL %s_out1_data: got %h expected 0", tag, AXIS_OUT1_TDATA[63:0]); end
    checks++;
    if (REQ_TREADY !== '0 || busy !== 1'b1 || AXIS_IN_TREADY !== 1'b0) begin errors++; $display("FAIL %s_send_state: got rdy=%b busy=%b in_rdy=%b expected 000/1/0", tag, REQ_TREADY, busy, AXIS_IN_TREADY); end
    checks++;
    AXIS_OUT0_TREADY = 1'b1; AXIS_OUT1_TREADY = 1'b1;
    tick;
    AXIS_OUT0_TREADY = 1'b0; AXIS_OUT1_TREADY = 1'b0;
    if (AXIS_IN_TREADY !== 1'b1 || AXIS_OUT0_TVALID !== 1'b0) begin errors++; $display("FAIL %s_wait: got in_rdy=%b out0_v=%b expected 1/0", tag, AXIS_IN_TREADY, AXIS_OUT0_TVALID); end
    checks++;
    AXIS_IN_TVALID = 1'b1; AXIS_IN_TDATA = rsp;
    tick;
    AXIS_IN_TVALID = 1'b0;
    if (RSP_TVALID !== exp_oh) begin errors++; $display("FAIL %s_rsp_valid: got %b expected %b", tag, RSP_TVALID, exp_oh); end
    checks++;
    if (RSP_TDATA !== rsp) begin errors++; $display("FAIL %s_rsp_data: got %h expected %h", tag, RSP_TDATA[66:0], rsp[66:0]); end
    checks++;
    RSP_TREADY = '1;
    tick;
    RSP_TREADY = '0;
    if (RSP_TVALID !== '0 || busy !== 1'b0) begin errors++; $display("FAIL %s_done: got rsp_v=%b busy=%b expected 000/0", tag, RSP_TVALID, busy); end
    checks++;
  endtask

  // Drive a grant for one requester and complete both request channels so
  // the DUT sits in WAIT_RSP on return.
  task automatic to_wait(input int owner, input string tag);
    REQ_TVALID = N'(1) << owner;
    #1;
    if (REQ_TREADY !== (N'(1) << owner)) begin errors++; $display("FAIL %s_grant: got %b expected %b", tag, REQ_TREADY, N'(1) << owner); end
    checks++;
    tick;
    REQ_TVALID = '0;
    AXIS_OUT0_TREADY = 1'b1; AXIS_OUT1_TREADY = 1'b1;
    tick;
    AXIS_OUT0_TREADY = 1'b0; AXIS_OUT1_TREADY = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    REQ_TVALID = 3'b111; RSP_TREADY = '0; AXIS_OUT0_TREADY = 1'b0; AXIS_OUT1_TREADY = 1'b0;
    AXIS_IN_TVALID = 1'b1; AXIS_IN_TDATA = '0;
    #2;
    if (REQ_TREADY !== '0 || RSP_TVALID !== '0 || AXIS_IN_TREADY !== 1'b0) begin errors++; $display("FAIL reset_ready: got req_rdy=%b rsp_v=%b in_rdy=%b expected 0", REQ_TREADY, RSP_TVALID, AXIS_IN_TREADY); end
    checks++;
    if (AXIS_OUT0_TVALID !== 1'b0 || AXIS_OUT1_TVALID !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b%b busy=%b expected 0", AXIS_OUT0_TVALID, AXIS_OUT1_TVALID, busy); end
    checks++;
    if (timeout_count !== 16'd0 || stale_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", timeout_count, stale_count); end
    checks++;
    if (AXIS_OUT0_TLAST !== 1'b1 || AXIS_OUT1_TLAST !== 1'b1) begin errors++; $display("FAIL tlast: got %b%b expected 11", AXIS_OUT0_TLAST, AXIS_OUT1_TLAST); end
    checks++;
    apply_reset;
  endtask

  task automatic test_single;
    REQ_TVALID = 3'b001;
    run_txn(0, rsp_pkt(32'h1000, 32'hF, 3'd0), 1'b1, "single");
  endtask

  task automatic test_round_robin;
    apply_reset;
    REQ_TVALID = 3'b111;
    for (int i = 0; i < 6; i++)
      run_txn(i % 3, rsp_pkt(32'h100 * i, 32'h10 + i, 3'd0), 1'b0, $sformatf("rr%0d", i));
    REQ_TVALID = '0;
  endtask

  task automatic test_backpressure;
    REQ_TVALID = 3'b001;
    #1;
    if (REQ_TREADY !== 3'b001) begin errors++; $display("FAIL bp_grant: got %b expected 001", REQ_TREADY); end
    checks++;
    tick;
    REQ_TVALID = '0;
    for (int c = 0; c < 8; c++) begin
      AXIS_OUT0_TREADY = (c == 2);
      AXIS_OUT1_TREADY = (c == 7);
      if (AXIS_OUT0_TVALID !== (c <= 2) || AXIS_OUT1_TVALID !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d: got %b%b expected %b1", c, AXIS_OUT0_TVALID, AXIS_OUT1_TVALID, (c <= 2)); end
      checks++;
      if (AXIS_IN_TREADY !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, AXIS_IN_TREADY); end
      checks++;
      tick;
    end
    AXIS_OUT0_TREADY = 1'b0; AXIS_OUT1_TREADY = 1'b0;
    if (AXIS_IN_TREADY !== 1'b1 || AXIS_OUT1_TVALID !== 1'b0) begin errors++; $display("FAIL bp_wait: got in_rdy=%b out1_v=%b expected 1/0", AXIS_IN_TREADY, AXIS_OUT1_TVALID); end
    checks++;
    AXIS_IN_TVALID = 1'b1; AXIS_IN_TDATA = rsp_pkt(32'h1000, 32'h7, 3'd2);
    tick;
    AXIS_IN_TVALID = 1'b0;
    if (RSP_TVALID !== 3'b001 || RSP_TDATA !== rsp_pkt(32'h1000, 32'h7, 3'd2)) begin errors++; $display("FAIL bp_rsp: got %b %h expected 001 slverr", RSP_TVALID, RSP_TDATA[66:0]); end
    checks++;
    RSP_TREADY = 3'b001;
    tick;
    RSP_TREADY = '0;
  endtask

  task automatic test_timeout;
    to_wait(1, "to");
    for (int k = 0; k < 16; k++) begin
      if (k == 15 && (AXIS_IN_TREADY !== 1'b1 || RSP_TVALID !== '0)) begin errors++; $display("FAIL to_still_waiting: got in_rdy=%b rsp_v=%b expected 1/000", AXIS_IN_TREADY, RSP_TVALID); end
      if (k == 15) checks++;
      tick;
    end
    if (RSP_TVALID !== 3'b010) begin errors++; $display("FAIL to_rsp_valid: got %b expected 010", RSP_TVALID); end
    checks++;
    if (RSP_TDATA !== rsp_pkt(32'hABCD0123, 32'h0, 3'd3)) begin errors++; $display("FAIL to_rsp_data: got %h expected decerr addr abcd0123", RSP_TDATA[66:0]); end
    checks++;
    if (timeout_count !== 16'd1) begin errors++; $display("FAIL to_count: got %0d expected 1", timeout_count); end
    checks++;
    RSP_TREADY = 3'b010;
    tick;
    RSP_TREADY = '0;
    AXIS_IN_TVALID = 1'b1; AXIS_IN_TDATA = rsp_pkt(32'hABCD0123, 32'h99, 3'd0);
    #1;
    if (AXIS_IN_TREADY !== 1'b1) begin errors++; $display("FAIL stale_ready: got %b expected 1", AXIS_IN_TREADY); end
    checks++;
    tick;
    AXIS_IN_TVALID = 1'b0;
    if (stale_count !== 16'd1 || RSP_TVALID !== '0 || busy !== 1'b0) begin errors++; $display("FAIL stale_drop: got cnt=%0d rsp_v=%b busy=%b expected 1/000/0", stale_count, RSP_TVALID, busy); end
    checks++;
  endtask

  task automatic test_timeout_race;
    to_wait(2, "race");
    repeat (15) tick;
    AXIS_IN_TVALID = 1'b1; AXIS_IN_TDATA = rsp_pkt(32'h20000040, 32'hAA, 3'd0);
    tick;
    AXIS_IN_TVALID = 1'b0;
    if (RSP_TVALID !== 3'b100 || RSP_TDATA !== rsp_pkt(32'h20000040, 32'hAA, 3'd0)) begin errors++; $display("FAIL race_rsp: got %b %h expected 100 real okay", RSP_TVALID, RSP_TDATA[66:0]); end
    checks++;
    if (timeout_count !== 16'd1 || stale_count !== 16'd1) begin errors++; $display("FAIL race_counts: got %0d/%0d expected 1/1", timeout_count, stale_count); end
    checks++;
    RSP_TREADY = 3'b100;
    tick;
    RSP_TREADY = '0;
  endtask

  task automatic test_rsp_hold;
    logic [255:0] rsp;
    rsp = rsp_pkt(32'h1000, 32'h5A5A, 3'd0);
    REQ_TVALID = 3'b111;
    #1;
    if (REQ_TREADY !== 3'b001) begin errors++; $display("FAIL hold_grant: got %b expected 001", REQ_TREADY); end
    checks++;
    tick;
    AXIS_OUT0_TREADY = 1'b1; AXIS_OUT1_TREADY = 1'b1;
    tick;
    AXIS_OUT0_TREADY = 1'b0; AXIS_OUT1_TREADY = 1'b0;
    AXIS_IN_TVALID = 1'b1; AXIS_IN_TDATA = rsp;
    tick;
    AXIS_IN_TVALID = 1'b0; AXIS_IN_TDATA = '1;
    RSP_TREADY = 3'b110;
    for (int c = 0; c < 10; c++) begin
      if (RSP_TVALID !== 3'b001 || RSP_TDATA !== rsp || REQ_TREADY !== '0) begin errors++; $display("FAIL hold_c%0d: got v=%b d=%h rdy=%b expected 001 stable 000", c, RSP_TVALID, RSP_TDATA[66:0], REQ_TREADY); end
      checks++;
      tick;
    end
    RSP_TREADY = 3'b001;
    tick;
    RSP_TREADY = '0;
    #1;
    if (REQ_TREADY !== 3'b010) begin errors++; $display("FAIL hold_next_grant: got %b expected 010", REQ_TREADY); end
    checks++;
    REQ_TVALID = '0;
    tick;
    if (busy !== 1'b0 || REQ_TREADY !== '0) begin errors++; $display("FAIL hold_withdrawn: got busy=%b rdy=%b expected 0/000", busy, REQ_TREADY); end
    checks++;
  endtask

  task automatic test_reset_mid;
    to_wait(1, "rst");
    if (AXIS_IN_TREADY !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_in_wait: got in_rdy=%b busy=%b expected 1/1", AXIS_IN_TREADY, busy); end
    checks++;
    REQ_TVALID = 3'b010;
    resetn = 1'b0;
    #1;
    if (REQ_TREADY !== '0 || AXIS_IN_TREADY !== 1'b0 || busy !== 1'b0 || RSP_TVALID !== '0) begin errors++; $display("FAIL rst_async: got rdy=%b in_rdy=%b busy=%b rsp_v=%b expected 0", REQ_TREADY, AXIS_IN_TREADY, busy, RSP_TVALID); end
    checks++;
    if (timeout_count !== 16'd0 || stale_count !== 16'd0 || RSP_TDATA !== '0 || AXIS_OUT0_TDATA !== '0) begin errors++; $display("FAIL rst_values: got to=%0d st=%0d expected 0/0 with zero data", timeout_count, stale_count); end
    checks++;
    REQ_TVALID = '0;
    tick; tick;
    resetn = 1'b1;
    tick;
    AXIS_IN_TVALID = 1'b1; AXIS_IN_TDATA = rsp_pkt(32'hABCD0123, 32'h1, 3'd0);
    tick;
    AXIS_IN_TVALID = 1'b0;
    if (stale_count !== 16'd1 || RSP_TVALID !== '0) begin errors++; $display("FAIL rst_stale: got cnt=%0d rsp_v=%b expected 1/000", stale_count, RSP_TVALID); end
    checks++;
    REQ_TVALID = 3'b100;
    run_txn(2, rsp_pkt(32'h20000040, 32'hBEEF, 3'd0), 1'b1, "rst_next");
  endtask

  initial begin
    pkt[0] = '0; pkt[0][31:0] = 32'h1000;     pkt[0][63:32] = 32'hF;
    pkt[1] = '0; pkt[1][31:0] = 32'hABCD0123; pkt[1][63:32] = 32'h55;
    pkt[2] = '0; pkt[2][31:0] = 32'h20000040; pkt[2][63:32] = 32'hAA;
    REQ_TDATA = {pkt[2], pkt[1], pkt[0]};
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_timeout;
    test_timeout_race;
    test_rsp_hold;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete within time limit");
    $fatal(1, "bench time limit reached");
  end

endmodule
